// File: rtl/sumrest_seq_ctrl.sv
// Serial W-bit add/subtract sequencer driving one external 4-bit adder/subtractor, LSB nibble first.
// Optional signed-overflow output enabled by defining SUMREST_SEQ_OVF_EN.
module sumrest_seq_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W  = 4 * NIBBLES,
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sign,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic [3:0]   nib_a,
   output logic [3:0]   nib_b,
   output logic         nib_sign,
   output logic         nib_cin,
   input  logic [3:0]   nib_sum,
   input  logic         nib_ct
`ifdef SUMREST_SEQ_OVF_EN
   ,
   output logic         ovf
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sign;
   } req_t;

   state_t        state, state_nx;
   req_t          req;
   logic [IW-1:0] idx;
   logic          carry;
   logic          last;

   assign last = (idx == IW'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath is only steered while RUN; otherwise it sees all-zero inputs.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      nib_a    = 4'h0;
      nib_b    = 4'h0;
      nib_sign = 1'b0;
      nib_cin  = 1'b0;
      case (state)
         RUN: begin
            busy     = 1'b1;
            nib_a    = req.a[4*idx +: 4];
            nib_b    = req.b[4*idx +: 4];
            nib_sign = req.sign;
            nib_cin  = carry;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Carry is preset to sign so subtraction becomes A + ~B + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         req    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               req   <= '{a: op_a, b: op_b, sign: sign};
               idx   <= '0;
               carry <= sign;
            end
            RUN: begin
               result[4*idx +: 4] <= nib_sum;
               carry              <= nib_ct;
               if (last) begin
                  cout <= nib_ct;
                  idx  <= '0;
               end else begin
                  idx  <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SUMREST_SEQ_OVF_EN
   // Carry into the MSB is recovered from the sum bit and the effective operand bits.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (state == RUN && last)
         ovf <= nib_ct ^ (nib_sum[3] ^ nib_a[3] ^ nib_b[3] ^ nib_sign);
   end
`endif

endmodule
